rr_packet_arbiter: RTL and testbench

//  Shares the single val/rdy SPI send wrapper between num_inputs packet producers
//  (PacketDisassemblers). Each producer sends fixed-length packets of FLITS flits.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_priority_picker.sv | 37 +++
 rtl/rr_packet_arbiter.sv | 119 +++++++++++
 tb/tb_rr_packet_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin packet arbiter.
//   arb_state_t : arbiter FSM state (IDLE = free to pick, LOCKED = mid-packet)
//   inc_mod     : increment an index modulo a (possibly non-power-of-two) count
package arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    function automatic int inc_mod(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Scans req starting just after 'last' (last+1, last+2, ... mod num_inputs)
// and returns the first requester found.
// Ports:
//   req  in  [0:num_inputs-1]  request bits
//   last in  addr_nbits        index that was served most recently
//   pick out addr_nbits        chosen index (last+1 mod num_inputs when nothing requests)
//   any  out 1                 at least one request is high
module rr_priority_picker
    import arb_pkg::*;
#(
    parameter int num_inputs = 3,
    parameter int addr_nbits = $clog2(num_inputs)
) (
    input  logic                  req [0:num_inputs-1],
    input  logic [addr_nbits-1:0] last,
    output logic [addr_nbits-1:0] pick,
    output logic                  any
);

    always_comb begin
        int idx;
        idx  = 0;
        pick = addr_nbits'(inc_mod(int'(last), num_inputs));
        any  = 1'b0;
        // Walk from the farthest candidate to the nearest so that the
        // nearest requester after 'last' is the final assignment.
        for (int k = num_inputs; k >= 1; k--) begin
            idx = (int'(last) + k) % num_inputs;
            if (req[idx]) begin
                pick = addr_nbits'(idx);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter sharing one val/rdy sender between num_inputs
// producers. The grant is picked round-robin in IDLE, held for a whole packet
// of FLITS flits in LOCKED, then rotates. Each outgoing flit is prefixed with
// the granted index. Datapath is purely combinational (zero latency).
// Ports:
//   clk       in  1                     clock, rising edge
//   reset     in  1                     asynchronous, active-high reset
//   recv_val  in  [0:num_inputs-1]      producer valid
//   recv_rdy  out [0:num_inputs-1]      producer ready (one-hot or zero)
//   recv_msg  in  nbits [0:num_inputs-1] producer flit
//   send_val  out 1                     to sender
//   send_rdy  in  1                     from sender
//   send_msg  out addr_nbits+nbits      {grant_idx, recv_msg[grant_idx]}
//   grant_idx out addr_nbits            current granted index
//   busy      out 1                     high while a packet is locked
module rr_packet_arbiter
    import arb_pkg::*;
#(
    parameter int nbits      = 32,
    parameter int num_inputs = 3,
    parameter int FLITS      = 4,
    parameter int addr_nbits = $clog2(num_inputs),
    parameter int cnt_nbits  = $clog2(FLITS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        recv_val [0:num_inputs-1],
    output logic                        recv_rdy [0:num_inputs-1],
    input  logic [nbits-1:0]            recv_msg [0:num_inputs-1],
    output logic                        send_val,
    input  logic                        send_rdy,
    output logic [addr_nbits+nbits-1:0] send_msg,
    output logic [addr_nbits-1:0]       grant_idx,
    output logic                        busy
);

    arb_state_t            state_q, state_d;
    logic [cnt_nbits-1:0]  cnt_q, cnt_d;
    logic [addr_nbits-1:0] last_q, last_d;
    logic [addr_nbits-1:0] grant_q, grant_d;

    logic [addr_nbits-1:0] pick;
    logic                  any_req;
    logic                  xfer;

    rr_priority_picker #(
        .num_inputs (num_inputs),
        .addr_nbits (addr_nbits)
    ) u_picker (
        .req  (recv_val),
        .last (last_q),
        .pick (pick),
        .any  (any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // Start "after" the last input so that input 0 is first in line.
            last_q  <= addr_nbits'(num_inputs - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        grant_idx = (state_q == LOCKED) ? grant_q : pick;
        // Outputs must be quiet for the whole reset pulse, not just after
        // the flops have cleared.
        if (reset) begin
            grant_idx = '0;
        end
        send_val = ~reset & recv_val[grant_idx];
        send_msg = {grant_idx, recv_msg[grant_idx]};
        busy     = ~reset & (state_q == LOCKED);
        for (int i = 0; i < num_inputs; i++) begin
            recv_rdy[i] = ~reset & send_rdy & (grant_idx == addr_nbits'(i));
        end
        xfer = send_val & send_rdy;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (FLITS == 1) begin
                        last_d = grant_idx;
                    end else begin
                        grant_d = grant_idx;
                        cnt_d   = cnt_nbits'(1);
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (cnt_q == cnt_nbits'(FLITS - 1)) begin
                        cnt_d   = '0;
                        last_d  = grant_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + cnt_nbits'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
module tb_rr_packet_arbiter;

    localparam int N  = 3;
    localparam int NB = 32;
    localparam int F  = 4;
    localparam int AW = 2;

    logic             clk;
    logic             reset;
    logic [N-1:0]     v;
    logic             rv [0:N-1];
    logic             rr [0:N-1];
    logic [N-1:0]     rdy_vec;
    logic [NB-1:0]    m [0:N-1];
    logic             send_val;
    logic             send_rdy;
    logic [AW+NB-1:0] send_msg;
    logic [AW-1:0]    grant_idx;
    logic             busy;

    // second instance with single-flit packets
    logic [N-1:0]     v1;
    logic             rv1 [0:N-1];
    logic             rr1 [0:N-1];
    logic             send_val1;
    logic             send_rdy1;
    logic [AW+NB-1:0] send_msg1;
    logic [AW-1:0]    grant_idx1;
    logic             busy1;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_locked;
    int          m_owner;
    int          m_last;
    int          m_count;

    rr_packet_arbiter #(.nbits(NB), .num_inputs(N), .FLITS(F)) dut (
        .clk(clk), .reset(reset), .recv_val(rv), .recv_rdy(rr), .recv_msg(m),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .grant_idx(grant_idx), .busy(busy)
    );

    rr_packet_arbiter #(.nbits(NB), .num_inputs(N), .FLITS(1)) dut1 (
        .clk(clk), .reset(reset), .recv_val(rv1), .recv_rdy(rr1), .recv_msg(m),
        .send_val(send_val1), .send_rdy(send_rdy1), .send_msg(send_msg1),
        .grant_idx(grant_idx1), .busy(busy1)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rv[i]      = v[i];
            rv1[i]     = v1[i];
            rdy_vec[i] = rr[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_locked) return m_owner;
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return (m_last + 1) % N;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_last   = N - 1;
        m_count  = 0;
    endtask

    task automatic randomize_msgs();
        for (int i = 0; i < N; i++) m[i] = $urandom;
    endtask

    // Inputs are set by the caller shortly after a falling edge.
    task automatic check_cycle();
        int          g;
        logic        esv;
        logic [N-1:0] erdy;
        g    = model_grant();
        esv  = v[g];
        erdy = send_rdy ? (N'(1) << g) : '0;
        #1;
        chk("grant_idx", 64'(grant_idx), 64'(g));
        chk("send_val", 64'(send_val), 64'(esv));
        chk("recv_rdy", 64'(rdy_vec), 64'(erdy));
        chk("send_msg", 64'(send_msg), 64'({AW'(g), m[g]}));
        chk("busy", 64'(busy), 64'(m_locked));
        @(posedge clk);
        if (esv && send_rdy) begin
            m_count++;
            if (m_count == F) begin
                m_count  = 0;
                m_locked = 0;
                m_last   = g;
            end else begin
                m_locked = 1;
                m_owner  = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        v        = '0;
        v1       = '0;
        send_rdy = 1'b0;
        send_rdy1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic [AW-1:0] g;
        logic         sv;
        logic [N-1:0] rr;
        logic         bz;
    } vec_t;

    vec_t tbl [5];
    int   order4 [4];
    int   order2 [4];
    logic [3:0] rdy_pat;

    initial begin
        tbl[0] = '{3'b010, 1'b1, 2'd1, 1'b1, 3'b010, 1'b0};
        tbl[1] = '{3'b010, 1'b1, 2'd1, 1'b1, 3'b010, 1'b1};
        tbl[2] = '{3'b010, 1'b1, 2'd1, 1'b1, 3'b010, 1'b1};
        tbl[3] = '{3'b010, 1'b1, 2'd1, 1'b1, 3'b010, 1'b1};
        tbl[4] = '{3'b010, 1'b1, 2'd1, 1'b1, 3'b010, 1'b0};
        order4 = '{0, 1, 2, 0};
        order2 = '{0, 2, 0, 2};

        // Outputs while reset is held, even with requests present
        reset = 1'b1; v = 3'b010; v1 = 3'b101; send_rdy = 1'b1; send_rdy1 = 1'b1;
        randomize_msgs();
        @(negedge clk); #1;
        chk("rst_send_val", 64'(send_val), 64'd0);
        chk("rst_recv_rdy", 64'(rdy_vec), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        do_reset();

        // Single producer, one full packet then a repeat grant to the same input
        for (int r = 0; r < 5; r++) begin
            v = tbl[r].v; send_rdy = tbl[r].rdy; randomize_msgs();
            #1;
            chk("tbl_grant", 64'(grant_idx), 64'(tbl[r].g));
            chk("tbl_send_val", 64'(send_val), 64'(tbl[r].sv));
            chk("tbl_recv_rdy", 64'(rdy_vec), 64'(tbl[r].rr));
            chk("tbl_busy", 64'(busy), 64'(tbl[r].bz));
            chk("tbl_send_msg", 64'(send_msg), 64'({2'd1, m[1]}));
            check_cycle();
        end

        // All inputs valid: packets rotate 0,1,2,0 and send_val never drops
        do_reset();
        for (int c = 0; c < 16; c++) begin
            v = 3'b111; send_rdy = 1'b1; randomize_msgs();
            #1;
            chk("rot_grant", 64'(grant_idx), 64'(order4[c / 4]));
            chk("rot_send_val", 64'(send_val), 64'd1);
            check_cycle();
        end

        // Locked producer stalls mid-packet while another input waits
        do_reset();
        for (int c = 0; c < 2; c++) begin
            v = 3'b001; send_rdy = 1'b1; randomize_msgs(); check_cycle();
        end
        for (int c = 0; c < 3; c++) begin
            v = 3'b100; send_rdy = 1'b1; randomize_msgs();
            #1;
            chk("stall_send_val", 64'(send_val), 64'd0);
            chk("stall_rdy2", 64'(rdy_vec[2]), 64'd0);
            chk("stall_grant", 64'(grant_idx), 64'd0);
            check_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            v = 3'b101; send_rdy = 1'b1; randomize_msgs();
            #1;
            chk("stall_tail_grant", 64'(grant_idx), 64'd0);
            check_cycle();
        end
        v = 3'b101; send_rdy = 1'b1; randomize_msgs();
        #1;
        chk("after_stall_grant", 64'(grant_idx), 64'd2);
        check_cycle();

        // Backpressure toggling mid-packet
        do_reset();
        rdy_pat = 4'b0101;
        v = 3'b010; send_rdy = 1'b1; randomize_msgs(); check_cycle();
        for (int c = 0; c < 4; c++) begin
            v = 3'b010; send_rdy = rdy_pat[c]; randomize_msgs();
            #1;
            chk("bp_grant", 64'(grant_idx), 64'd1);
            chk("bp_rdy_mirror", 64'(rdy_vec), 64'(send_rdy ? 3'b010 : 3'b000));
            check_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            v = 3'b010; send_rdy = 1'b1; randomize_msgs(); check_cycle();
        end

        // Asynchronous reset in the middle of a packet
        do_reset();
        for (int c = 0; c < 2; c++) begin
            v = 3'b010; send_rdy = 1'b1; randomize_msgs(); check_cycle();
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_send_val", 64'(send_val), 64'd0);
        chk("arst_recv_rdy", 64'(rdy_vec), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_grant", 64'(grant_idx), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        v = 3'b011; send_rdy = 1'b1; randomize_msgs();
        #1;
        chk("post_rst_grant", 64'(grant_idx), 64'd0);
        check_cycle();
        for (int c = 0; c < 4; c++) begin
            v = 3'b011; send_rdy = 1'b1; randomize_msgs(); check_cycle();
        end

        // Single-flit packets alternate between inputs 0 and 2
        do_reset();
        for (int c = 0; c < 4; c++) begin
            v1 = 3'b101; send_rdy1 = 1'b1; randomize_msgs();
            #1;
            chk("f1_grant", 64'(grant_idx1), 64'(order2[c]));
            chk("f1_busy", 64'(busy1), 64'd0);
            chk("f1_send_val", 64'(send_val1), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        v1 = '0; send_rdy1 = 1'b0;

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = N'($urandom_range(0, 7));
            send_rdy = ($urandom_range(0, 3) != 0);
            randomize_msgs();
            check_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
